// File: rtl/alu_despachador.sv
// alu_despachador: accepts one ALU request and routes its operands to the
// arithmetic unit (f2=1) or the boolean unit (f2=0). It holds them for
// LATENCIA cycles, captures the selected unit's result and flags, and
// presents them downstream over a valid/ready handshake.
//
// state    | meaning
// INACTIVO | idle, ready for a request, unit buses zero
// DESPACHO | operands driven to the selected unit, latency countdown
// ENTREGA  | captured result offered downstream, waiting for sal_listo
module alu_despachador #(
  parameter int ANCHO    = 32,
  parameter int LATENCIA = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ent_valido,
  output logic             ent_listo,
  input  logic [ANCHO-1:0] ent_A,
  input  logic [ANCHO-1:0] ent_B,
  input  logic [3:0]       ent_f,
  output logic [ANCHO-1:0] arit_A,
  output logic [ANCHO-1:0] arit_B,
  output logic [3:0]       arit_f,
  output logic [ANCHO-1:0] bool_A,
  output logic [ANCHO-1:0] bool_B,
  output logic [3:0]       bool_f,
  input  logic [ANCHO-1:0] arit_res,
  input  logic [3:0]       arit_flags,
  input  logic [ANCHO-1:0] bool_res,
  input  logic [3:0]       bool_flags,
  output logic             sal_valido,
  input  logic             sal_listo,
  output logic [ANCHO-1:0] sal_res,
  output logic [3:0]       sal_flags,
  output logic             sal_sel
);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    DESPACHO = 2'd1,
    ENTREGA  = 2'd2
  } estado_t;

  estado_t          estado, estado_sig;
  logic [ANCHO-1:0] reg_A, reg_B;
  logic [3:0]       reg_f;
  logic [3:0]       cnt;
  logic             aceptar, capturar, entregar;

  assign aceptar  = (estado == INACTIVO) && ent_valido;
  assign capturar = (estado == DESPACHO) && (cnt == 4'd0);
  assign entregar = (estado == ENTREGA) && sal_listo;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) estado <= INACTIVO;
    else       estado <= estado_sig;
  end

  // Next state and unit buses; buses come only from registers so they stay
  // stable for the whole DESPACHO interval.
  always_comb begin
    estado_sig = estado;
    ent_listo  = 1'b0;
    sal_valido = 1'b0;
    arit_A     = '0;
    arit_B     = '0;
    arit_f     = '0;
    bool_A     = '0;
    bool_B     = '0;
    bool_f     = '0;
    case (estado)
      INACTIVO: begin
        ent_listo = 1'b1;
        if (ent_valido) estado_sig = DESPACHO;
      end
      DESPACHO: begin
        if (reg_f[2]) begin
          arit_A = reg_A;
          arit_B = reg_B;
          arit_f = reg_f;
        end else begin
          bool_A = reg_A;
          bool_B = reg_B;
          bool_f = reg_f;
        end
        if (cnt == 4'd0) estado_sig = ENTREGA;
      end
      ENTREGA: begin
        sal_valido = 1'b1;
        if (sal_listo) estado_sig = INACTIVO;
      end
      default: estado_sig = INACTIVO;
    endcase
  end

  // Request registers, latency counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_A     <= '0;
      reg_B     <= '0;
      reg_f     <= '0;
      cnt       <= '0;
      sal_res   <= '0;
      sal_flags <= '0;
      sal_sel   <= 1'b0;
    end else begin
      if (aceptar) begin
        reg_A <= ent_A;
        reg_B <= ent_B;
        reg_f <= ent_f;
        cnt   <= 4'(LATENCIA - 1);
      end else if (estado == DESPACHO && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capturar) begin
        sal_res   <= reg_f[2] ? arit_res : bool_res;
        sal_flags <= reg_f[2] ? arit_flags : bool_flags;
        sal_sel   <= reg_f[2];
      end
      // Buses are zero outside DESPACHO anyway; clearing the operands after
      // delivery keeps stale data out of the registers.
      if (entregar) begin
        reg_A <= '0;
        reg_B <= '0;
        reg_f <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_despachador.sv
// Directed bench for alu_despachador: one instance with LATENCIA=1 and one
// with LATENCIA=4, each fed by stub arithmetic (A+B) and boolean (A&B) units.
module tb_alu_despachador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ent_valido, ent_valido4, sal_listo, sal_listo4;
  logic [31:0] ent_A, ent_B, bias;
  logic [3:0]  ent_f;

  logic        ent_listo1, sal_valido1, sal_sel1;
  logic [31:0] arit_A1, arit_B1, bool_A1, bool_B1, arit_res1, bool_res1, sal_res1;
  logic [3:0]  arit_f1, bool_f1, arit_flags1, bool_flags1, sal_flags1;

  logic        ent_listo4, sal_valido4, sal_sel4;
  logic [31:0] arit_A4, arit_B4, bool_A4, bool_B4, arit_res4, bool_res4, sal_res4;
  logic [3:0]  arit_f4, bool_f4, arit_flags4, bool_flags4, sal_flags4;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [3:0] fl_arit(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[32], s[31:0] == 32'd0, s[31], (a[31] == b[31]) && (s[31] != a[31])};
  endfunction

  function automatic logic [3:0] fl_bool(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a & b;
    return {1'b0, r == 32'd0, r[31], 1'b1};
  endfunction

  assign arit_res1   = arit_A1 + arit_B1;
  assign arit_flags1 = fl_arit(arit_A1, arit_B1);
  assign bool_res1   = bool_A1 & bool_B1;
  assign bool_flags1 = fl_bool(bool_A1, bool_B1);
  assign arit_res4   = arit_A4 + arit_B4 + bias;
  assign arit_flags4 = fl_arit(arit_A4, arit_B4);
  assign bool_res4   = bool_A4 & bool_B4;
  assign bool_flags4 = fl_bool(bool_A4, bool_B4);

  alu_despachador #(.ANCHO(32), .LATENCIA(1)) dut1 (
    .clk(clk), .reset(reset),
    .ent_valido(ent_valido), .ent_listo(ent_listo1),
    .ent_A(ent_A), .ent_B(ent_B), .ent_f(ent_f),
    .arit_A(arit_A1), .arit_B(arit_B1), .arit_f(arit_f1),
    .bool_A(bool_A1), .bool_B(bool_B1), .bool_f(bool_f1),
    .arit_res(arit_res1), .arit_flags(arit_flags1),
    .bool_res(bool_res1), .bool_flags(bool_flags1),
    .sal_valido(sal_valido1), .sal_listo(sal_listo),
    .sal_res(sal_res1), .sal_flags(sal_flags1), .sal_sel(sal_sel1)
  );

  alu_despachador #(.ANCHO(32), .LATENCIA(4)) dut4 (
    .clk(clk), .reset(reset),
    .ent_valido(ent_valido4), .ent_listo(ent_listo4),
    .ent_A(ent_A), .ent_B(ent_B), .ent_f(ent_f),
    .arit_A(arit_A4), .arit_B(arit_B4), .arit_f(arit_f4),
    .bool_A(bool_A4), .bool_B(bool_B4), .bool_f(bool_f4),
    .arit_res(arit_res4), .arit_flags(arit_flags4),
    .bool_res(bool_res4), .bool_flags(bool_flags4),
    .sal_valido(sal_valido4), .sal_listo(sal_listo4),
    .sal_res(sal_res4), .sal_flags(sal_flags4), .sal_sel(sal_sel4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] op_A[8], op_B[8], ex_res[8];
  logic [3:0]  op_f[8], ex_flags[8];
  logic [3:0]  f_tmp;
  int          acc, dlv;
  logic        fire_in, fire_out;

  initial begin
    reset = 1'b1; ent_valido = 1'b0; ent_valido4 = 1'b0;
    sal_listo = 1'b1; sal_listo4 = 1'b1; bias = '0;
    ent_A = '0; ent_B = '0; ent_f = '0;

    // Reset state
    tick;
    chk("rst_ent_listo", ent_listo1, 1);
    chk("rst_sal_valido", sal_valido1, 0);
    chk("rst_sal_res", sal_res1, 0);
    chk("rst_sal_flags", sal_flags1, 0);
    chk("rst_sal_sel", sal_sel1, 0);
    chk("rst_arit_A", arit_A1, 0);
    chk("rst_bool_A", bool_A1, 0);
    chk("rst4_ent_listo", ent_listo4, 1);
    reset = 1'b0;
    tick;

    // Arithmetic path
    ent_valido = 1'b1; ent_A = 32'h1; ent_B = 32'h1; ent_f = 4'b0101;
    tick;
    ent_valido = 1'b0; ent_A = 32'hDEAD; ent_f = 4'b0000;
    chk("ar_ent_listo", ent_listo1, 0);
    chk("ar_arit_A", arit_A1, 32'h1);
    chk("ar_arit_B", arit_B1, 32'h1);
    chk("ar_arit_f", arit_f1, 4'b0101);
    chk("ar_bool_A", bool_A1, 0);
    chk("ar_bool_f", bool_f1, 0);
    chk("ar_early_valid", sal_valido1, 0);
    tick;
    chk("ar_valid", sal_valido1, 1);
    chk("ar_res", sal_res1, 32'h2);
    chk("ar_sel", sal_sel1, 1);
    chk("ar_flags", sal_flags1, 4'b0000);
    chk("ar_bus_zero", arit_A1, 0);
    tick;
    chk("ar_done_valid", sal_valido1, 0);
    chk("ar_done_listo", ent_listo1, 1);

    // Boolean path
    ent_valido = 1'b1; ent_A = 32'hF0F0F0F0; ent_B = 32'hFF00FF00; ent_f = 4'b1001;
    tick;
    ent_valido = 1'b0;
    chk("bo_arit_A", arit_A1, 0);
    chk("bo_arit_f", arit_f1, 0);
    chk("bo_bool_A", bool_A1, 32'hF0F0F0F0);
    chk("bo_bool_B", bool_B1, 32'hFF00FF00);
    chk("bo_bool_f", bool_f1, 4'b1001);
    tick;
    chk("bo_valid", sal_valido1, 1);
    chk("bo_res", sal_res1, 32'hF000F000);
    chk("bo_sel", sal_sel1, 0);
    chk("bo_flags", sal_flags1, 4'b0011);
    tick;

    // Backpressure with a second request waiting
    sal_listo = 1'b0;
    ent_valido = 1'b1; ent_A = 32'd3; ent_B = 32'd4; ent_f = 4'b0100;
    tick;
    ent_A = 32'd10; ent_B = 32'd20; ent_f = 4'b0000;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", sal_valido1, 1);
      chk("bp_res", sal_res1, 32'd7);
      chk("bp_flags", sal_flags1, 4'b0000);
      chk("bp_ent_listo", ent_listo1, 0);
      tick;
    end
    sal_listo = 1'b1;
    chk("bp_res_last", sal_res1, 32'd7);
    tick;
    chk("bp_bubble_valid", sal_valido1, 0);
    chk("bp_bubble_listo", ent_listo1, 1);
    tick;
    ent_valido = 1'b0;
    chk("bp_acc_listo", ent_listo1, 0);
    chk("bp_acc_boolA", bool_A1, 32'd10);
    chk("bp_acc_boolB", bool_B1, 32'd20);
    tick;
    chk("bp2_valid", sal_valido1, 1);
    chk("bp2_res", sal_res1, 32'd0);
    chk("bp2_flags", sal_flags1, 4'b0101);
    chk("bp2_sel", sal_sel1, 0);
    tick;

    // LATENCIA=4: only the stub value present in the 4th cycle is captured
    ent_valido4 = 1'b1; ent_A = 32'd5; ent_B = 32'd6; ent_f = 4'b0100;
    tick;
    ent_valido4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("lat_hold_A", arit_A4, 32'd5);
      chk("lat_hold_B", arit_B4, 32'd6);
      chk("lat_no_valid", sal_valido4, 0);
      bias = 32'(100 * k);
      tick;
    end
    chk("lat_valid", sal_valido4, 1);
    chk("lat_res", sal_res4, 32'd411);
    chk("lat_sel", sal_sel4, 1);
    chk("lat_bus_zero", arit_A4, 0);
    tick;
    chk("lat_done", sal_valido4, 0);
    bias = '0;

    // Reset mid-operation
    ent_valido = 1'b1; ent_A = 32'd7; ent_B = 32'd8; ent_f = 4'b0100;
    tick;
    ent_valido = 1'b0;
    chk("ra_despacho", arit_A1, 32'd7);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("ra_ent_listo", ent_listo1, 1);
    chk("ra_sal_valido", sal_valido1, 0);
    chk("ra_arit_A", arit_A1, 0);
    chk("ra_arit_B", arit_B1, 0);
    chk("ra_bool_A", bool_A1, 0);
    chk("ra_sal_res", sal_res1, 0);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("ra_no_pulse", sal_valido1, 0);
    end

    // Back-to-back alternating requests with random downstream readiness
    for (int i = 0; i < 8; i++) begin
      op_A[i] = $urandom;
      op_B[i] = $urandom;
      f_tmp = 4'($urandom_range(0, 15));
      f_tmp[2] = (i % 2 == 0);
      op_f[i] = f_tmp;
      ex_res[i]   = f_tmp[2] ? op_A[i] + op_B[i] : op_A[i] & op_B[i];
      ex_flags[i] = f_tmp[2] ? fl_arit(op_A[i], op_B[i]) : fl_bool(op_A[i], op_B[i]);
    end
    acc = 0; dlv = 0;
    for (int cyc = 0; cyc < 400 && dlv < 8; cyc++) begin
      sal_listo = 1'($urandom_range(0, 1));
      if (acc < 8) begin
        ent_valido = 1'b1; ent_A = op_A[acc]; ent_B = op_B[acc]; ent_f = op_f[acc];
      end else begin
        ent_valido = 1'b0; ent_A = $urandom; ent_B = $urandom;
      end
      fire_in  = ent_valido && ent_listo1;
      fire_out = sal_valido1 && sal_listo;
      if (fire_out) begin
        chk("b2b_res", sal_res1, ex_res[dlv]);
        chk("b2b_flags", sal_flags1, ex_flags[dlv]);
        chk("b2b_sel", sal_sel1, op_f[dlv][2]);
        chk("b2b_order", dlv, acc - 1);
        dlv++;
      end
      tick;
      if (fire_in) acc++;
    end
    chk("b2b_delivered", dlv, 8);
    chk("b2b_accepted", acc, 8);
    ent_valido = 1'b0; sal_listo = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("b2b_no_dup", sal_valido1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
